// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sa_pkg
//  Description : Shared definitions for the systolic-array result path:
//                operand/partial widths, full-precision merge width, the
//                row-major element packing index and the streaming FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package sa_pkg;

    localparam int W      = 8;             // width of one INT or Frac operand part
    localparam int F      = 8;             // fraction bits carried by a Frac operand
    localparam int SUM_W  = 2*W + F + 2;   // full-precision merge width
    localparam int N_ELEM = 16;            // 4x4 result matrix

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Packed position of element (row, col); column varies fastest.
    function automatic logic [3:0] elem_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage
`default_nettype wire

// File: rtl/sa_fxp_combine.sv
`default_nettype none
// ============================================================================
//  Module      : sa_fxp_combine
//  Description : Purely combinational merge of one INTxINT, INTxFrac and
//                FracxINT partial product into a single signed fixed-point
//                value, followed by saturation to OUT_W bits.
//                Build option SA_COMB_ROUND_EN: round half-up by DROP_BITS
//                before saturation (output scale becomes 2^(F-DROP_BITS)).
//  Ports       : i_ii, i_if, i_fi  2W-bit signed partials
//                o_data            OUT_W-bit signed result
//                o_sat             result was clamped
//  Revision    : 1.0  initial release
// ============================================================================
module sa_fxp_combine #(
    parameter int W         = 8,
    parameter int F         = 8,
    parameter int OUT_W     = 24,
    parameter int DROP_BITS = 4
) (
    input  logic [2*W-1:0]   i_ii,
    input  logic [2*W-1:0]   i_if,
    input  logic [2*W-1:0]   i_fi,
    output logic [OUT_W-1:0] o_data,
    output logic             o_sat
);

    localparam int SUM_W = 2*W + F + 2;
    localparam int EXT_W = SUM_W - 2*W;
    // Bits between the output sign position and the sum sign bit; they must all
    // equal the sum sign bit for the value to fit in OUT_W.
    localparam int HI_W  = SUM_W - OUT_W;

    logic signed [SUM_W-1:0] w_ii_sh;
    logic signed [SUM_W-1:0] w_if_ext;
    logic signed [SUM_W-1:0] w_fi_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_val;
    logic        [HI_W-1:0]  w_hi;

    // INTxINT carries weight 2^F relative to the mixed partials.
    assign w_ii_sh  = {{(EXT_W-F){i_ii[2*W-1]}}, i_ii, {F{1'b0}}};
    assign w_if_ext = {{EXT_W{i_if[2*W-1]}}, i_if};
    assign w_fi_ext = {{EXT_W{i_fi[2*W-1]}}, i_fi};
    assign w_sum    = w_ii_sh + w_if_ext + w_fi_ext;

`ifdef SA_COMB_ROUND_EN
    localparam logic signed [SUM_W-1:0] c_half = SUM_W'(1 << (DROP_BITS-1));

    logic signed [SUM_W-1:0] w_rnd;

    // The sum has two guard bits of headroom, so adding half an LSB cannot wrap.
    assign w_rnd = w_sum + c_half;
    assign w_val = w_rnd >>> DROP_BITS;
`else
    assign w_val = w_sum;
`endif

    assign w_hi = w_val[SUM_W-2:OUT_W-1];

    always_comb begin
        o_data = w_val[OUT_W-1:0];
        o_sat  = 1'b0;
        if (!w_val[SUM_W-1] && (|w_hi)) begin
            o_data = {1'b0, {(OUT_W-1){1'b1}}};
            o_sat  = 1'b1;
        end else if (w_val[SUM_W-1] && !(&w_hi)) begin
            o_data = {1'b1, {(OUT_W-1){1'b0}}};
            o_sat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sa_result_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : sa_result_combiner
//  Description : Captures the three 4x4 partial-product matrices of the
//                systolic arrays on their done strobe, merges each element into
//                one saturated fixed-point value and streams the 16 results
//                row-major over a valid/ready interface.
//                Build option SA_COMB_ROUND_EN (see sa_fxp_combine) enables
//                half-up rounding by DROP_BITS; timing is unchanged.
//  Ports       : clk, _reset          clock, synchronous active-high reset
//                done                 partial buses valid this cycle
//                res_ii/res_if/res_fi 16 x 2W signed partials, element (r,c)
//                                     at bits [(4r+c)*2W +: 2W]
//                out_data/out_valid/out_ready  result stream
//                out_row/out_col/out_last      element position, last marker
//                out_sat              current element was clamped
//                busy                 capture held or streaming
//                drop_err             sticky: a done strobe was ignored
//  Revision    : 1.0  initial release
// ============================================================================
module sa_result_combiner #(
    parameter int W         = sa_pkg::W,
    parameter int F         = sa_pkg::F,
    parameter int OUT_W     = 24,
    parameter int DROP_BITS = 4
) (
    input  logic                clk,
    input  logic                _reset,
    input  logic                done,
    input  logic [16*2*W-1:0]   res_ii,
    input  logic [16*2*W-1:0]   res_if,
    input  logic [16*2*W-1:0]   res_fi,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_row,
    output logic [1:0]          out_col,
    output logic                out_last,
    output logic                out_sat,
    output logic                busy,
    output logic                drop_err
);

    import sa_pkg::*;

    localparam int PART_W = 2*W;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_idx;
    logic [PART_W-1:0] r_buf_ii [N_ELEM];
    logic [PART_W-1:0] r_buf_if [N_ELEM];
    logic [PART_W-1:0] r_buf_fi [N_ELEM];
    logic [OUT_W-1:0]  r_data;
    logic              r_sat;
    logic              r_drop_err;

    logic              w_streaming;
    logic              w_hs;
    logic              w_at_last;
    logic              w_last_hs;
    logic              w_capture;
    logic              w_advance;
    logic              w_drop;
    logic [3:0]        w_src_idx;
    logic [PART_W-1:0] w_src_ii;
    logic [PART_W-1:0] w_src_if;
    logic [PART_W-1:0] w_src_fi;
    logic [OUT_W-1:0]  w_comb_data;
    logic              w_comb_sat;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    assign w_streaming = (r_state == STREAM);
    assign w_hs        = w_streaming && out_ready;
    assign w_at_last   = (r_idx == 4'd15);
    assign w_last_hs   = w_hs && w_at_last;
    // A new set is accepted when idle, or exactly on the final handshake so
    // that consecutive matrices stream without a bubble.
    assign w_capture   = done && (!w_streaming || w_last_hs);
    assign w_advance   = w_hs && !w_at_last;
    assign w_drop      = done && w_streaming && !w_last_hs;

    // ------------------------------------------------------------------
    // Combiner source: on a capture the first element comes straight from
    // the input buses, since the buffers only hold it from the next cycle.
    // ------------------------------------------------------------------
    assign w_src_idx = w_capture ? 4'd0 : r_idx + 4'd1;
    assign w_src_ii  = w_capture ? res_ii[PART_W-1:0] : r_buf_ii[w_src_idx];
    assign w_src_if  = w_capture ? res_if[PART_W-1:0] : r_buf_if[w_src_idx];
    assign w_src_fi  = w_capture ? res_fi[PART_W-1:0] : r_buf_fi[w_src_idx];

    sa_fxp_combine #(
        .W         (W),
        .F         (F),
        .OUT_W     (OUT_W),
        .DROP_BITS (DROP_BITS)
    ) u_combine (
        .i_ii   (w_src_ii),
        .i_if   (w_src_if),
        .i_fi   (w_src_fi),
        .o_data (w_comb_data),
        .o_sat  (w_comb_sat)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (done) w_state_nxt = STREAM;
            STREAM:  if (w_last_hs && !done) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Index counter, output register and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (_reset) begin
            r_idx      <= 4'd0;
            r_data     <= '0;
            r_sat      <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_capture || w_advance) begin
                r_idx  <= w_src_idx;
                r_data <= w_comb_data;
                r_sat  <= w_comb_sat;
            end else if (w_last_hs) begin
                r_idx  <= 4'd0;
            end
            if (w_drop) begin
                r_drop_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture buffers. They are only read after a capture has written
    // them, so they carry no reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    r_buf_ii[elem_idx(2'(r), 2'(c))] <= res_ii[elem_idx(2'(r), 2'(c))*PART_W +: PART_W];
                    r_buf_if[elem_idx(2'(r), 2'(c))] <= res_if[elem_idx(2'(r), 2'(c))*PART_W +: PART_W];
                    r_buf_fi[elem_idx(2'(r), 2'(c))] <= res_fi[elem_idx(2'(r), 2'(c))*PART_W +: PART_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_data  = r_data;
    assign out_valid = w_streaming;
    assign out_row   = r_idx[3:2];
    assign out_col   = r_idx[1:0];
    assign out_last  = w_streaming && w_at_last;
    assign out_sat   = r_sat;
    assign busy      = w_streaming;
    assign drop_err  = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_sa_result_combiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sa_result_combiner
//  Description : Directed self-checking bench for sa_result_combiner:
//                reset state, nominal merge, negative/rounding vectors,
//                saturation, backpressure, overlapping done, mid-stream reset.
//                Expected values follow SA_COMB_ROUND_EN when it is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sa_result_combiner;

    localparam int PART_W = 16;
    localparam int OUT_W  = 24;

    logic                 clk = 1'b0;
    logic                 _reset;
    logic                 done;
    logic [16*PART_W-1:0] res_ii;
    logic [16*PART_W-1:0] res_if;
    logic [16*PART_W-1:0] res_fi;
    logic [OUT_W-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_row;
    logic [1:0]           out_col;
    logic                 out_last;
    logic                 out_sat;
    logic                 busy;
    logic                 drop_err;

    int                   n_checks = 0;
    int                   n_errors = 0;
    logic [OUT_W-1:0]     exp_data [16];
    logic                 exp_sat  [16];
    logic [OUT_W-1:0]     nxt_data [16];
    logic                 nxt_sat  [16];

    sa_result_combiner dut (
        .clk       (clk),
        ._reset    (_reset),
        .done      (done),
        .res_ii    (res_ii),
        .res_if    (res_if),
        .res_fi    (res_fi),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: ii*2^8 + if + fi, optional half-up rounding by 4, clamp to 24 bits.
    function automatic logic [24:0] model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        longint s;
        s = longint'($signed(a)) * 256 + longint'($signed(b)) + longint'($signed(c));
`ifdef SA_COMB_ROUND_EN
        s = (s + 8) >>> 4;
`endif
        if (s > 64'sd8388607)  return {1'b1, 24'h7FFFFF};
        if (s < -64'sd8388608) return {1'b1, 24'h800000};
        return {1'b0, s[23:0]};
    endfunction

    task automatic set_elem(input int e, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        res_ii[e*PART_W +: PART_W] = a;
        res_if[e*PART_W +: PART_W] = b;
        res_fi[e*PART_W +: PART_W] = c;
    endtask

    task automatic fill_all(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
        for (int e = 0; e < 16; e++) set_elem(e, a, b, c);
    endtask

    // Expected stream derived from whatever is currently on the buses.
    task automatic exp_from_bus(output logic [OUT_W-1:0] d [16], output logic s [16]);
        logic [24:0] m;
        for (int e = 0; e < 16; e++) begin
            m    = model(res_ii[e*PART_W +: PART_W], res_if[e*PART_W +: PART_W], res_fi[e*PART_W +: PART_W]);
            d[e] = m[23:0];
            s[e] = m[24];
        end
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    // Consume one full stream and compare every presented cycle, including
    // stalled ones, against exp_data/exp_sat.
    task automatic drain(input bit stall);
        int beat = 0;
        int cyc  = 0;
        while (beat < 16 && cyc < 200) begin
            out_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            check($sformatf("valid[%0d]", beat), out_valid, 1);
            check($sformatf("busy[%0d]", beat), busy, 1);
            check($sformatf("data[%0d]", beat), out_data, exp_data[beat]);
            check($sformatf("row[%0d]", beat), out_row, beat / 4);
            check($sformatf("col[%0d]", beat), out_col, beat % 4);
            check($sformatf("last[%0d]", beat), out_last, beat == 15);
            check($sformatf("sat[%0d]", beat), out_sat, exp_sat[beat]);
            if (out_ready) beat++;
            tick();
            cyc++;
        end
        check("drain_beats", beat, 16);
        out_ready = 1'b0;
    endtask

    initial begin
        _reset    = 1'b1;
        done      = 1'b0;
        out_ready = 1'b0;
        res_ii    = '0;
        res_if    = '0;
        res_fi    = '0;
        repeat (2) tick();
        _reset = 1'b0;

        // ---- reset state ----
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop_err", drop_err, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_sat", out_sat, 0);

        // ---- nominal merge: 0x100 + 0x80 + 0x40 = 0x1C0 ----
        fill_all(16'h0001, 16'h0080, 16'h0040);
        for (int e = 0; e < 16; e++) begin
`ifdef SA_COMB_ROUND_EN
            exp_data[e] = 24'h00001C;
`else
            exp_data[e] = 24'h0001C0;
`endif
            exp_sat[e]  = 1'b0;
        end
        out_ready = 1'b1;
        pulse_done();
        drain(0);
        check("nom_valid_after", out_valid, 0);
        check("nom_busy_after", busy, 0);

        // ---- rounding / negative vectors: 0x1C0, 0x1C8, -24 ----
        fill_all(16'h0000, 16'h0000, 16'h0000);
        set_elem(0, 16'h0001, 16'h0080, 16'h0040);
        set_elem(1, 16'h0001, 16'h00C8, 16'h0000);
        set_elem(2, 16'h0000, 16'hFFE8, 16'h0000);
        for (int e = 0; e < 16; e++) begin
            exp_data[e] = 24'h0;
            exp_sat[e]  = 1'b0;
        end
`ifdef SA_COMB_ROUND_EN
        exp_data[0] = 24'h00001C;
        exp_data[1] = 24'h00001D;
        exp_data[2] = 24'hFFFFFF;
`else
        exp_data[0] = 24'h0001C0;
        exp_data[1] = 24'h0001C8;
        exp_data[2] = 24'hFFFFE8;
`endif
        pulse_done();
        drain(0);

        // ---- positive saturation ----
        fill_all(16'h7FFF, 16'h7FFF, 16'h7FFF);
`ifdef SA_COMB_ROUND_EN
        exp_from_bus(exp_data, exp_sat);
`else
        for (int e = 0; e < 16; e++) begin
            exp_data[e] = 24'h7FFFFF;
            exp_sat[e]  = 1'b1;
        end
`endif
        pulse_done();
        drain(0);

        // ---- negative saturation ----
        fill_all(16'h8000, 16'h8000, 16'h8000);
`ifdef SA_COMB_ROUND_EN
        exp_from_bus(exp_data, exp_sat);
`else
        for (int e = 0; e < 16; e++) begin
            exp_data[e] = 24'h800000;
            exp_sat[e]  = 1'b1;
        end
`endif
        pulse_done();
        drain(0);

        // ---- backpressure with distinct per-element values ----
        for (int e = 0; e < 16; e++) set_elem(e, 16'(e + 1), 16'(e * 17), 16'(-e));
        exp_from_bus(exp_data, exp_sat);
        pulse_done();
        drain(1);
        check("bp_drop_err", drop_err, 0);

        // ---- overlap: dropped done at beat 5, accepted on last handshake ----
        for (int e = 0; e < 16; e++) set_elem(e, 16'(e), 16'h0003, 16'h0000);
        exp_from_bus(exp_data, exp_sat);
        pulse_done();
        for (int e = 0; e < 16; e++) set_elem(e, 16'(100 + e), 16'h0000, 16'h0005);
        exp_from_bus(nxt_data, nxt_sat);
        out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            check($sformatf("ovl_data[%0d]", b), out_data, exp_data[b]);
            check($sformatf("ovl_idx[%0d]", b), {out_row, out_col}, b);
            done = (b == 5) || (b == 15);
            tick();
            done = 1'b0;
            if (b == 5) check("ovl_drop_err", drop_err, 1);
        end
        check("ovl_valid_nogap", out_valid, 1);
        check("ovl_new_first", out_data, nxt_data[0]);
        exp_data = nxt_data;
        exp_sat  = nxt_sat;
        drain(0);
        check("ovl_drop_err_sticky", drop_err, 1);

        // ---- reset mid-stream at beat 7 ----
        for (int e = 0; e < 16; e++) set_elem(e, 16'(e + 3), 16'h0010, 16'h0000);
        exp_from_bus(exp_data, exp_sat);
        pulse_done();
        out_ready = 1'b1;
        for (int b = 0; b < 7; b++) begin
            check($sformatf("mid_data[%0d]", b), out_data, exp_data[b]);
            tick();
        end
        check("mid_idx7", {out_row, out_col}, 7);
        _reset = 1'b1;
        tick();
        _reset = 1'b0;
        out_ready = 1'b0;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_drop_err", drop_err, 0);
        check("mid_rst_data", out_data, 0);
        tick();
        check("mid_idle_valid", out_valid, 0);
        for (int e = 0; e < 16; e++) set_elem(e, 16'(-e), 16'h0001, 16'h0002);
        exp_from_bus(exp_data, exp_sat);
        pulse_done();
        drain(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
